workout_progress_tracker: RTL and testbench

- Monitors the workout scheduler's outputs (workout_num, time_remain, buzzer) and the user's start/skip controls.
- Reconstructs the session as a stream of per-workout completion records.
- Each record holds the workout number, the cycles spent on it, and a skipped flag, buffered in a small FIFO behind a valid/ready port for the display/logging path.
- Keeps running completed/skipped counters and session status flags.

---
 rtl/workout_progress_tracker.sv | 235 +++++++++++++++++++++++
 tb/tb_workout_progress_tracker.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/workout_progress_tracker.sv
// -----------------------------------------------------------------------------
// workout_progress_tracker
//
// Watches the workout scheduler (workout_num, buzzer) and the user's start/skip
// pulses and rebuilds the session as a stream of per-workout completion
// records. Each record carries the workout number, the number of RUN cycles
// spent on it and whether it was ended by a skip. Records are queued in a small
// FIFO behind a valid/ready port for the display/logging path. Running
// completed/skipped counters and session status flags are also kept.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   start         session start pulse (shared with the scheduler)
//   skip          user skip pulse (shared with the scheduler)
//   workout_num   scheduler's current workout number
//   time_remain   scheduler's remaining time (observed only, no effect)
//   buzzer        scheduler end-of-workout buzzer
//   rec_valid     head record available
//   rec_ready     consumer accepts the head record
//   rec_num       head record: workout number
//   rec_cycles    head record: RUN cycles spent on the workout
//   rec_skipped   head record: 1 = ended by skip
//   done_count    workouts completed by buzzer this session
//   skip_count    workouts ended by skip this session
//   busy          high while a session is running
//   session_done  high once the session has produced all its records
//   overflow      sticky: a record was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module workout_progress_tracker #(
  parameter int unsigned NUM_WORKOUTS = 8,
  parameter int unsigned ELAPSED_W    = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 skip,
  input  logic [7:0]           workout_num,
  input  logic [5:0]           time_remain,
  input  logic                 buzzer,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [7:0]           rec_num,
  output logic [ELAPSED_W-1:0] rec_cycles,
  output logic                 rec_skipped,
  output logic [7:0]           done_count,
  output logic [7:0]           skip_count,
  output logic                 busy,
  output logic                 session_done,
  output logic                 overflow
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(NUM_WORKOUTS + 1);

  localparam logic [ELAPSED_W-1:0] ElapsedMax = '1;
  localparam logic [CntW-1:0]      NumRec     = CntW'(NUM_WORKOUTS);
  localparam logic [7:0]           CountMax   = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef struct packed {
    logic [7:0]           num;
    logic [ELAPSED_W-1:0] cycles;
    logic                 skipped;
  } rec_t;

  // Session state
  state_e               state_q;
  logic [ELAPSED_W-1:0] elapsed_q;
  logic [CntW-1:0]      rec_cnt_q;
  logic [7:0]           done_cnt_q;
  logic [7:0]           skip_cnt_q;
  logic                 buzz_prev_q;
  logic                 busy_q;
  logic                 sess_done_q;

  // Record FIFO; pointers carry one extra bit to tell full from empty
  rec_t                 mem_q [FIFO_DEPTH];
  logic [AddrW:0]       wr_ptr_q;
  logic [AddrW:0]       rd_ptr_q;
  logic                 overflow_q;

  // Decode
  logic                 buzz_rise;
  logic                 rec_event;
  logic [ELAPSED_W-1:0] elapsed_inc;
  logic [CntW-1:0]      rec_cnt_inc;
  logic [7:0]           done_cnt_inc;
  logic [7:0]           skip_cnt_inc;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  rec_t                 new_rec;
  rec_t                 head_rec;

  // time_remain is observed but deliberately has no effect on the outputs.
  logic                 unused_time_remain;
  assign unused_time_remain = ^time_remain;

  // A buzzer that is already high when RUN is entered shows no rising edge,
  // because buzz_prev_q tracks the buzzer in every state.
  assign buzz_rise = buzzer & ~buzz_prev_q;
  assign rec_event = (state_q == StRun) & (buzz_rise | skip);

  assign elapsed_inc  = (elapsed_q == ElapsedMax) ? elapsed_q : elapsed_q + 1'b1;
  assign rec_cnt_inc  = rec_cnt_q + 1'b1;
  assign done_cnt_inc = (done_cnt_q == CountMax) ? done_cnt_q : done_cnt_q + 1'b1;
  assign skip_cnt_inc = (skip_cnt_q == CountMax) ? skip_cnt_q : skip_cnt_q + 1'b1;

  // The record's cycle count includes the event cycle itself.
  assign new_rec.num     = workout_num;
  assign new_rec.cycles  = elapsed_inc;
  assign new_rec.skipped = skip;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign pop  = ~fifo_empty & rec_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = rec_event & (~fifo_full | pop);

  // ---------------------------------------------------------------------------
  // Session FSM with registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      elapsed_q   <= '0;
      rec_cnt_q   <= '0;
      done_cnt_q  <= '0;
      skip_cnt_q  <= '0;
      busy_q      <= 1'b0;
      sess_done_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StRun;
            elapsed_q   <= '0;
            rec_cnt_q   <= '0;
            done_cnt_q  <= '0;
            skip_cnt_q  <= '0;
            busy_q      <= 1'b1;
            sess_done_q <= 1'b0;
          end
        end
        StRun: begin
          if (rec_event) begin
            elapsed_q <= '0;
            rec_cnt_q <= rec_cnt_inc;
            // A skip coinciding with a buzzer edge counts only as a skip.
            if (skip) begin
              skip_cnt_q <= skip_cnt_inc;
            end else begin
              done_cnt_q <= done_cnt_inc;
            end
            // Dropped records still count toward the session length.
            if (rec_cnt_inc == NumRec) begin
              state_q     <= StDone;
              busy_q      <= 1'b0;
              sess_done_q <= 1'b1;
            end
          end else begin
            elapsed_q <= elapsed_inc;
          end
        end
        default: begin
          state_q     <= StIdle;
          busy_q      <= 1'b0;
          sess_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      buzz_prev_q <= 1'b0;
    end else begin
      buzz_prev_q <= buzzer;
    end
  end

  // ---------------------------------------------------------------------------
  // Record FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rec_event && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= new_rec;
    end
  end

  assign head_rec = mem_q[rd_ptr_q[AddrW-1:0]];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rec_valid    = ~fifo_empty;
  assign rec_num      = rec_valid ? head_rec.num     : '0;
  assign rec_cycles   = rec_valid ? head_rec.cycles  : '0;
  assign rec_skipped  = rec_valid ? head_rec.skipped : 1'b0;
  assign done_count   = done_cnt_q;
  assign skip_count   = skip_cnt_q;
  assign busy         = busy_q;
  assign session_done = sess_done_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_workout_progress_tracker.sv
// -----------------------------------------------------------------------------
// tb_workout_progress_tracker
//
// Directed scenarios followed by random stimulus. A behavioural model, updated
// just after every rising edge, tracks the session (phase, elapsed cycles,
// counters, FIFO occupancy) and pushes every accepted record into a
// scoreboard queue. A separate monitor on the falling edge compares status
// outputs against the model and pops/compares records as the DUT hands them
// out.
// -----------------------------------------------------------------------------
module tb_workout_progress_tracker;

  localparam int NumW   = 8;
  localparam int ElW    = 4;
  localparam int Depth  = 4;
  localparam int ElMax  = (1 << ElW) - 1;

  logic           clk;
  logic           reset;
  logic           start;
  logic           skip;
  logic [7:0]     workout_num;
  logic [5:0]     time_remain;
  logic           buzzer;
  logic           rec_valid;
  logic           rec_ready;
  logic [7:0]     rec_num;
  logic [ElW-1:0] rec_cycles;
  logic           rec_skipped;
  logic [7:0]     done_count;
  logic [7:0]     skip_count;
  logic           busy;
  logic           session_done;
  logic           overflow;

  workout_progress_tracker #(
    .NUM_WORKOUTS (NumW),
    .ELAPSED_W    (ElW),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .skip         (skip),
    .workout_num  (workout_num),
    .time_remain  (time_remain),
    .buzzer       (buzzer),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_num      (rec_num),
    .rec_cycles   (rec_cycles),
    .rec_skipped  (rec_skipped),
    .done_count   (done_count),
    .skip_count   (skip_count),
    .busy         (busy),
    .session_done (session_done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: session phase 0=idle, 1=running, 2=finished
  // ---------------------------------------------------------------------------
  typedef struct {
    int num;
    int cyc;
    int sk;
  } rec_t;

  rec_t sb_q[$];
  int   m_phase = 0;
  int   m_el    = 0;
  int   m_gen   = 0;
  int   m_dc    = 0;
  int   m_sc    = 0;
  int   m_occ   = 0;
  bit   m_ovf   = 1'b0;
  bit   m_bprev = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Applies the effect of the edge that just happened, using the inputs that
  // were held across it.
  task automatic model_edge();
    bit   rise;
    bit   ev;
    bit   pop_m;
    bit   acc;
    rec_t r;
    if (!reset) begin
      m_phase = 0;
      m_el    = 0;
      m_gen   = 0;
      m_dc    = 0;
      m_sc    = 0;
      m_occ   = 0;
      m_ovf   = 1'b0;
      m_bprev = 1'b0;
      sb_q.delete();
    end else begin
      rise  = buzzer && !m_bprev;
      pop_m = (m_occ > 0) && rec_ready;
      ev    = 1'b0;
      r     = '{num: 0, cyc: 0, sk: 0};
      if (m_phase == 1) begin
        ev = rise || skip;
        if (ev) begin
          r.num = int'(workout_num);
          r.cyc = sat(m_el + 1, ElMax);
          r.sk  = skip ? 1 : 0;
          m_el  = 0;
          m_gen++;
          if (skip) m_sc = sat(m_sc + 1, 255);
          else      m_dc = sat(m_dc + 1, 255);
          if (m_gen == NumW) m_phase = 2;
        end else begin
          m_el = sat(m_el + 1, ElMax);
        end
      end else if (start) begin
        m_phase = 1;
        m_el    = 0;
        m_gen   = 0;
        m_dc    = 0;
        m_sc    = 0;
      end
      acc = ev && ((m_occ < Depth) || pop_m);
      if (ev && !acc) m_ovf = 1'b1;
      if (acc) sb_q.push_back(r);
      m_occ = m_occ - (pop_m ? 1 : 0) + (acc ? 1 : 0);
      m_bprev = buzzer;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 model_edge();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("session_done", 32'(session_done), 32'(m_phase == 2));
      chk("done_count", 32'(done_count), 32'(m_dc));
      chk("skip_count", 32'(skip_count), 32'(m_sc));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("rec_valid", 32'(rec_valid), 32'(m_occ > 0));
      if (m_occ > 0 && sb_q.size() > 0) begin
        chk("rec_num", 32'(rec_num), 32'(sb_q[0].num));
        chk("rec_cycles", 32'(rec_cycles), 32'(sb_q[0].cyc));
        chk("rec_skipped", 32'(rec_skipped), 32'(sb_q[0].sk));
        if (rec_ready && reset) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0; start = 1'b0; skip = 1'b0; buzzer = 1'b0;
    rec_ready = 1'b1; workout_num = 8'd0; time_remain = 6'd0;
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_rec_num", 32'(rec_num), 32'd0);
    chk("rst_rec_cycles", 32'(rec_cycles), 32'd0);
    reset = 1'b1;

    // Basic record: buzzer rises on the 10th RUN cycle
    workout_num = 8'd3; start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    buzzer = 1'b1; tick();
    chk("basic_valid", 32'(rec_valid), 32'd1);
    chk("basic_num", 32'(rec_num), 32'd3);
    chk("basic_cycles", 32'(rec_cycles), 32'd10);
    chk("basic_skipped", 32'(rec_skipped), 32'd0);
    chk("basic_done_count", 32'(done_count), 32'd1);
    buzzer = 1'b0;

    // Skip, then skip coinciding with a buzzer edge
    reset = 1'b0; tick(); reset = 1'b1;
    workout_num = 8'd5; start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    skip = 1'b1; tick(); skip = 1'b0;
    chk("skip_num", 32'(rec_num), 32'd5);
    chk("skip_cycles", 32'(rec_cycles), 32'd4);
    chk("skip_flag", 32'(rec_skipped), 32'd1);
    repeat (5) tick();
    skip = 1'b1; buzzer = 1'b1; tick(); skip = 1'b0; buzzer = 1'b0;
    chk("simul_cycles", 32'(rec_cycles), 32'd6);
    chk("simul_flag", 32'(rec_skipped), 32'd1);
    chk("simul_skip_count", 32'(skip_count), 32'd2);
    chk("simul_done_count", 32'(done_count), 32'd0);

    // Session end after 8 records, DONE ignores events, restart
    for (int i = 0; i < 6; i++) begin
      buzzer = 1'b0; repeat (2) tick();
      buzzer = 1'b1; tick();
    end
    chk("end_session_done", 32'(session_done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      buzzer = 1'b0; tick();
      buzzer = 1'b1; tick();
    end
    chk("done_no_records", 32'(rec_valid), 32'd0);
    chk("done_count_held", 32'(done_count), 32'd6);
    buzzer = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done_cnt", 32'(done_count), 32'd0);
    chk("restart_skip_cnt", 32'(skip_count), 32'd0);

    // Backpressure: 5 events into a 4-deep FIFO
    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      workout_num = 8'(10 + i);
      buzzer = 1'b0; tick();
      buzzer = 1'b1; tick();
    end
    buzzer = 1'b0;
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_valid", 32'(rec_valid), 32'd1);
    chk("bp_head_cycles", 32'(rec_cycles), 32'd2);
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_order", 32'(rec_num), 32'(10 + i));
      tick();
    end
    chk("bp_drained", 32'(rec_valid), 32'd0);

    // Full FIFO with push and pop in the same cycle
    reset = 1'b0; tick(); reset = 1'b1;
    rec_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      workout_num = 8'(20 + i);
      buzzer = 1'b0; tick();
      buzzer = 1'b1; tick();
    end
    workout_num = 8'd24;
    buzzer = 1'b0; tick();
    rec_ready = 1'b1; buzzer = 1'b1; tick();
    chk("pushpop_no_ovf", 32'(overflow), 32'd0);
    chk("pushpop_head", 32'(rec_num), 32'd21);
    buzzer = 1'b0; repeat (5) tick();

    // Buzzer already high at start
    reset = 1'b0; buzzer = 1'b1; tick(); reset = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("hi_buzz_no_rec", 32'(rec_valid), 32'd0);
    buzzer = 1'b0; repeat (2) tick();
    buzzer = 1'b1; tick();
    chk("hi_buzz_cycles", 32'(rec_cycles), 32'd8);
    buzzer = 1'b0; tick();

    // Reset mid-RUN with 2 records queued
    rec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      buzzer = 1'b0; tick();
      buzzer = 1'b1; tick();
    end
    buzzer = 1'b0;
    chk("mid_queued", 32'(rec_valid), 32'd1);
    reset = 1'b0; tick();
    chk("mid_rst_valid", 32'(rec_valid), 32'd0);
    chk("mid_rst_num", 32'(rec_num), 32'd0);
    chk("mid_rst_cycles", 32'(rec_cycles), 32'd0);
    chk("mid_rst_skipped", 32'(rec_skipped), 32'd0);
    chk("mid_rst_done", 32'(done_count), 32'd0);
    chk("mid_rst_skip", 32'(skip_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sdone", 32'(session_done), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1; rec_ready = 1'b1;

    // Elapsed saturation: event on the 20th RUN cycle
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    buzzer = 1'b1; tick();
    chk("sat_cycles", 32'(rec_cycles), 32'(ElMax));
    buzzer = 1'b0;

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      reset       = ($urandom_range(0, 299) != 0);
      start       = ($urandom_range(0, 19) == 0);
      skip        = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 5) == 0) buzzer = ~buzzer;
      rec_ready   = ($urandom_range(0, 9) < 6);
      workout_num = 8'($urandom);
      time_remain = 6'($urandom);
      tick();
    end

    // Drain
    reset = 1'b1; start = 1'b0; skip = 1'b0; buzzer = 1'b0; rec_ready = 1'b1;
    repeat (8) tick();
    chk("drain_scoreboard", 32'(sb_q.size()), 32'd0);
    chk("drain_valid", 32'(rec_valid), 32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
